// File: rtl/i2s_tx.sv
// I2S master transmitter: divides in_mclk into sclk/fclk and shifts left/right samples out MSB-first.
// Latency: a pair strobed >= 1 cycle before a frame start puts its left MSB on out_dout one sclk period after fclk falls.
// Backpressure: one-entry holding buffer; out_frame_ready low while full, extra strobes are dropped and flagged.
//
// Ports:
//   in_mclk, in_reset                 sole clock (rising edge) and async active-high reset
//   in_frame_left/right/strobe        sample pair write into the holding buffer
//   out_frame_ready                   holding buffer empty
//   out_sclk, out_fclk, out_dout      I2S bit clock, word clock (0 = left), serial data
//   out_frame_start, out_underflow,   one-cycle pulses: frame start, frame started with empty buffer,
//   out_overrun                       strobe dropped because the buffer was full
module i2s_tx #(
  parameter int G_BITS      = 16,
  parameter int G_SLOT_BITS = 32,
  parameter int G_MCLK_DIV  = 4
) (
  input  logic              in_mclk,
  input  logic              in_reset,
  input  logic [G_BITS-1:0] in_frame_left,
  input  logic [G_BITS-1:0] in_frame_right,
  input  logic              in_frame_strobe,
  output logic              out_frame_ready,
  output logic              out_sclk,
  output logic              out_fclk,
  output logic              out_dout,
  output logic              out_frame_start,
  output logic              out_underflow,
  output logic              out_overrun
);

  localparam int FRAME_BITS = 2 * G_SLOT_BITS;
  localparam int DIV_W      = (G_MCLK_DIV > 2) ? $clog2(G_MCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(G_MCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_MCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(G_SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_END = BIT_W'(G_BITS);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              buf_full;
  logic [G_BITS-1:0] buf_left;
  logic [G_BITS-1:0] buf_right;
  logic [G_BITS-1:0] sr_left;
  logic [G_BITS-1:0] sr_right;

  logic              fall_evt;
  logic              frame_evt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  k_nxt;
  logic              slot_nxt;
  logic              data_bit;

  // Everything is decided on the value bit_cnt is about to take, so the
  // registered fclk/dout line up with the new bit at the sclk falling edge.
  always_comb begin
    fall_evt  = (div_cnt == DIV_LAST);
    bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    slot_nxt  = (bit_nxt >= SLOT);
    k_nxt     = slot_nxt ? (bit_nxt - SLOT) : bit_nxt;
    frame_evt = fall_evt && (bit_nxt == '0);
    // k=0 is the I2S one-bit delay slot; bits past G_BITS pad with zero.
    data_bit  = (k_nxt != '0) && (k_nxt <= DATA_END);
  end

  always_ff @(posedge in_mclk or posedge in_reset) begin
    if (in_reset) begin
      div_cnt         <= '0;
      bit_cnt         <= BIT_LAST;
      buf_full        <= 1'b0;
      buf_left        <= '0;
      buf_right       <= '0;
      sr_left         <= '0;
      sr_right        <= '0;
      out_sclk        <= 1'b0;
      out_fclk        <= 1'b1;
      out_dout        <= 1'b0;
      out_frame_ready <= 1'b1;
      out_frame_start <= 1'b0;
      out_underflow   <= 1'b0;
      out_overrun     <= 1'b0;
    end else begin
      out_frame_start <= 1'b0;
      out_underflow   <= 1'b0;
      out_overrun     <= 1'b0;

      div_cnt <= fall_evt ? '0 : div_cnt + DIV_W'(1);
      if (div_cnt == DIV_HALF) begin
        out_sclk <= 1'b1;
      end

      if (fall_evt) begin
        out_sclk <= 1'b0;
        bit_cnt  <= bit_nxt;
        out_fclk <= slot_nxt;
        out_dout <= 1'b0;
        if (frame_evt) begin
          out_frame_start <= 1'b1;
          if (buf_full) begin
            sr_left  <= buf_left;
            sr_right <= buf_right;
          end else begin
            // Nothing queued: send a silent frame and flag it.
            sr_left       <= '0;
            sr_right      <= '0;
            out_underflow <= 1'b1;
          end
        end else if (data_bit) begin
          if (slot_nxt) begin
            out_dout <= sr_right[G_BITS-1];
            sr_right <= sr_right << 1;
          end else begin
            out_dout <= sr_left[G_BITS-1];
            sr_left  <= sr_left << 1;
          end
        end
      end

      // A frame-start load frees the buffer in the same cycle, so a
      // coincident strobe refills it instead of being counted as overrun.
      if (in_frame_strobe && (!buf_full || frame_evt)) begin
        buf_left        <= in_frame_left;
        buf_right       <= in_frame_right;
        buf_full        <= 1'b1;
        out_frame_ready <= 1'b0;
      end else if (in_frame_strobe) begin
        out_overrun <= 1'b1;
      end else if (frame_evt) begin
        buf_full        <= 1'b0;
        out_frame_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: reference model derived from elapsed cycles since reset plus a pair queue,
// compared against every output on each falling in_mclk edge, plus a behavioural I2S receiver
// and literal expectations for latency, slot bit patterns, overrun/underflow and reset behaviour.
module tb_i2s_tx;

  localparam int B  = 16;
  localparam int S  = 32;
  localparam int D  = 4;
  localparam int FR = 2 * S * D;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [B-1:0] in_l = '0;
  logic [B-1:0] in_r = '0;
  logic         stb = 1'b0;
  logic         rdy, sclk, fclk, dout, fs, uf, ov;

  always #5 clk = ~clk;

  i2s_tx #(.G_BITS(B), .G_SLOT_BITS(S), .G_MCLK_DIV(D)) dut (
    .in_mclk         (clk),
    .in_reset        (rst),
    .in_frame_left   (in_l),
    .in_frame_right  (in_r),
    .in_frame_strobe (stb),
    .out_frame_ready (rdy),
    .out_sclk        (sclk),
    .out_fclk        (fclk),
    .out_dout        (dout),
    .out_frame_start (fs),
    .out_underflow   (uf),
    .out_overrun     (ov)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int               m_n = 0;
  logic [B-1:0]     m_cur_l = '0;
  logic [B-1:0]     m_cur_r = '0;
  logic [2*B-1:0]   m_buf[$];
  logic             m_fs = 1'b0, m_uf = 1'b0, m_ov = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0;
      m_buf.delete();
      m_cur_l = '0; m_cur_r = '0;
      m_fs = 1'b0; m_uf = 1'b0; m_ov = 1'b0;
    end else begin
      m_n++;
      m_fs = 1'b0; m_uf = 1'b0; m_ov = 1'b0;
      if (m_n >= D && (m_n - D) % FR == 0) begin
        m_fs = 1'b1;
        if (m_buf.size() > 0) {m_cur_l, m_cur_r} = m_buf.pop_front();
        else begin
          m_cur_l = '0; m_cur_r = '0; m_uf = 1'b1;
        end
      end
      if (stb) begin
        if (m_buf.size() == 0) m_buf.push_back({in_l, in_r});
        else m_ov = 1'b1;
      end
    end
  end

  function automatic logic [6:0] model_out();
    int           nb, bit_i, k;
    logic         e_sclk, e_fclk, e_dout;
    logic [B-1:0] w;
    e_sclk = ((m_n % D) >= D / 2);
    nb     = m_n / D;
    bit_i  = (nb + 2 * S - 1) % (2 * S);
    e_fclk = (bit_i >= S);
    k      = bit_i % S;
    w      = e_fclk ? m_cur_r : m_cur_l;
    e_dout = (k >= 1 && k <= B) ? w[B-k] : 1'b0;
    return {e_sclk, e_fclk, e_dout, m_fs, m_uf, m_ov, (m_buf.size() == 0)};
  endfunction

  always @(negedge clk) begin
    check("cycle {sclk,fclk,dout,fs,uf,ov,rdy}", 64'({sclk, fclk, dout, fs, uf, ov, rdy}), 64'(model_out()));
  end

  int ov_cnt = 0;
  always @(negedge clk) if (ov === 1'b1) ov_cnt++;

  // ---------------- behavioural I2S receiver ----------------
  int             rk = S;
  logic           rlast_f = 1'b1;
  logic [S-1:0]   rslot = '0;
  logic [S-1:0]   rx_lslot = '0;
  logic [S-1:0]   rx_rslot = '0;
  logic [2*B-1:0] rx_q[$];

  function automatic logic [B-1:0] slot_word(input logic [S-1:0] s);
    logic [B-1:0] w;
    w = '0;
    for (int k = 1; k <= B; k++) w[B-k] = s[k];
    return w;
  endfunction

  always @(posedge sclk or posedge rst) begin
    if (rst) begin
      rk = S; rlast_f = 1'b1;
    end else begin
      if (fclk != rlast_f) rk = 0;
      else if (rk < 2 * S) rk++;
      rlast_f = fclk;
      if (rk < S) rslot[rk] = dout;
      if (rk == S - 1) begin
        if (!fclk) rx_lslot = rslot;
        else begin
          rx_rslot = rslot;
          rx_q.push_back({slot_word(rx_lslot), slot_word(rx_rslot)});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (m_n != target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (m_n != target) begin
      chk_cnt++;
      $display("FAIL wait_n: reached cycle %0d required %0d", m_n, target);
    end
  endtask

  task automatic strobe_pair(input logic [B-1:0] a, input logic [B-1:0] b);
    in_l = a; in_r = b; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  localparam logic [S-1:0] NON_DATA = 32'hFFFE_0001;

  initial begin
    logic acc;
    logic [2*B-1:0] exp_rx [6];
    exp_rx = '{32'hA5C3_0F01, 32'h1234_8001, 32'hFFFF_0000,
               32'h0000_0000, 32'h1111_2222, 32'h5555_6666};

    // Reset, no strobe: silent frame with underflow.
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset outputs", 64'({sclk, fclk, dout, fs, uf, ov, rdy}), 64'(7'b0100001));
    @(negedge clk);
    rst = 1'b0;
    wait_n(3);
    check("fclk high before first frame", 64'(fclk), 64'(1'b1));
    wait_n(4);
    check("first frame {fclk,fs,uf}", 64'({fclk, fs, uf}), 64'(3'b011));
    acc = 1'b0;
    for (int i = 0; i < FR; i++) begin
      acc = acc | dout;
      @(negedge clk);
    end
    check("dout silent in underflow frame", 64'(acc), 64'(1'b0));

    // Fresh reset, pair strobed before the first frame.
    #2 rst = 1'b1;
    @(negedge clk);
    rx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    strobe_pair(16'hA5C3, 16'h0F01);
    check("ready low after capture", 64'(rdy), 64'(1'b0));
    wait_n(3);
    check("ready low before frame start", 64'(rdy), 64'(1'b0));
    wait_n(4);
    check("frame start {fs,uf,rdy}", 64'({fs, uf, rdy}), 64'(3'b101));
    wait_n(100);
    strobe_pair(16'h1234, 16'h8001);
    wait_n(262);
    check("left slot word", 64'(slot_word(rx_lslot)), 64'(16'hA5C3));
    check("right slot word", 64'(slot_word(rx_rslot)), 64'(16'h0F01));
    check("left slot padding", 64'(rx_lslot & NON_DATA), 64'(0));
    check("right slot padding", 64'(rx_rslot & NON_DATA), 64'(0));
    wait_n(300);
    strobe_pair(16'hFFFF, 16'h0000);

    // Two strobes while full inside the underflow frame 3.
    wait_n(772);
    ov_cnt = 0;
    wait_n(800);
    strobe_pair(16'h1111, 16'h2222);
    wait_n(810);
    strobe_pair(16'h3333, 16'h4444);
    wait_n(1027);
    check("single overrun pulse", 64'(ov_cnt), 64'(1));

    // Strobe exactly on a frame-start cycle with the buffer full.
    wait_n(1100);
    strobe_pair(16'h5555, 16'h6666);
    wait_n(1283);
    strobe_pair(16'h7777, 16'h8888);
    check("same-cycle load {fs,rdy,ov}", 64'({fs, rdy, ov}), 64'(3'b100));
    wait_n(1290);
    check("buffer still full", 64'(rdy), 64'(1'b0));
    check("no overrun on same-cycle load", 64'(ov_cnt), 64'(1));

    // Reset mid right slot with a pair pending.
    wait_n(1600);
    strobe_pair(16'h9999, 16'hAAAA);
    wait_n(1700);
    check("pending pair held", 64'(rdy), 64'(1'b0));
    check("in right slot", 64'(fclk), 64'(1'b1));
    #2 rst = 1'b1;
    #1 check("async reset outputs", 64'({sclk, fclk, dout, fs, uf, ov, rdy}), 64'(7'b0100001));
    check("received pair count", 64'(rx_q.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < rx_q.size()) check($sformatf("received pair %0d", i), 64'(rx_q[i]), 64'(exp_rx[i]));
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wait_n(3);
    check("fclk high after reset release", 64'(fclk), 64'(1'b1));
    wait_n(4);
    check("post-reset frame {fclk,fs,uf,rdy}", 64'({fclk, fs, uf, rdy}), 64'(4'b0111));
    wait_n(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
